i2c_master_writer: RTL and testbench

//  Parametrised I2C write master: sends START, NBYTES bytes MSB-first, samples ACK after each

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_tick_gen.sv | 28 ++
 rtl/i2c_master_writer.sv | 165 ++++++++++++++++
 tb/tb_i2c_master_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C write master: FSM states, quarter-phase index and slot helpers.
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

  typedef logic [1:0] quarter_t;

  localparam int unsigned QUARTERS_PER_BIT = 4;
  localparam quarter_t    Q_LAST           = quarter_t'(QUARTERS_PER_BIT - 1);

  // SCL is low for the first half of a bit slot and high for the second half.
  function automatic logic slot_scl(input quarter_t q);
    return q[1];
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period strobe generator: one-cycle tick every CLK_DIV enabled cycles.
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = i_en && (cnt_q == CW'(CLK_DIV - 1));

  // Held at zero while disabled so the first quarter after accept is full length.
  always_comb begin
    cnt_d = '0;
    if (i_en && !o_tick) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master_writer.sv
// I2C write master: START, NBYTES bytes MSB-first with ACK sampling, STOP; open-drain SDA.
module i2c_master_writer
  import i2c_pkg::*;
#(
  parameter int unsigned NBYTES  = 3,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [8*NBYTES-1:0]   i_dat,
  output logic                  o_busy,
  output logic                  o_finished,
  output logic                  o_ack_err,
  output logic                  o_sclk,
  inout  wire                   o_sdat
);

  localparam int unsigned DW = 8 * NBYTES;
  localparam int unsigned BW = $clog2(NBYTES + 1);

  state_t          state_q, state_d;
  quarter_t        qtr_q, qtr_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [BW-1:0]   byte_idx_q, byte_idx_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic            busy_q, busy_d;
  logic            fin_q, fin_d;
  logic            err_q, err_d;
  logic            scl_q, scl_d;
  logic            sda_oe_q, sda_oe_d;
  logic            tick;
  logic            sda_in;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (state_q != IDLE),
    .o_tick (tick)
  );

  assign o_sdat     = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in     = o_sdat;
  assign o_busy     = busy_q;
  assign o_finished = fin_q;
  assign o_ack_err  = err_q;
  assign o_sclk     = scl_q;

  // Outputs are registered for the quarter being entered, so each branch sets
  // SCL/SDA for the next phase at the same tick that advances the phase.
  always_comb begin
    state_d    = state_q;
    qtr_d      = qtr_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    busy_d     = busy_q;
    fin_d      = 1'b0;
    err_d      = err_q;
    scl_d      = scl_q;
    sda_oe_d   = sda_oe_q;
    unique case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        if (i_start) begin
          state_d  = START;
          qtr_d    = '0;
          shreg_d  = i_dat;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          sda_oe_d = 1'b1;
        end
      end
      START: if (tick) begin
        if (qtr_q == quarter_t'(1)) begin
          state_d    = BIT;
          qtr_d      = '0;
          bit_idx_d  = 3'd7;
          byte_idx_d = BW'(NBYTES - 1);
          scl_d      = 1'b0;
          sda_oe_d   = ~shreg_q[DW-1];
        end else begin
          qtr_d = qtr_q + 1'b1;
        end
      end
      BIT: if (tick) begin
        if (qtr_q == Q_LAST) begin
          shreg_d = shreg_q << 1;
          qtr_d   = '0;
          scl_d   = 1'b0;
          if (bit_idx_q == 3'd0) begin
            state_d  = ACK;
            sda_oe_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q - 1'b1;
            sda_oe_d  = ~shreg_q[DW-2];
          end
        end else begin
          qtr_d = qtr_q + 1'b1;
          scl_d = slot_scl(qtr_q + 1'b1);
        end
      end
      ACK: if (tick) begin
        if (qtr_q == quarter_t'(2) && sda_in != 1'b0) err_d = 1'b1;
        if (qtr_q == Q_LAST) begin
          qtr_d = '0;
          scl_d = 1'b0;
          if (err_q || byte_idx_q == '0) begin
            state_d  = STOP;
            sda_oe_d = 1'b1;
          end else begin
            state_d    = BIT;
            byte_idx_d = byte_idx_q - 1'b1;
            bit_idx_d  = 3'd7;
            sda_oe_d   = ~shreg_q[DW-1];
          end
        end else begin
          qtr_d = qtr_q + 1'b1;
          scl_d = slot_scl(qtr_q + 1'b1);
        end
      end
      STOP: if (tick) begin
        unique case (qtr_q)
          quarter_t'(0): begin qtr_d = quarter_t'(1); scl_d = 1'b1; end
          quarter_t'(1): begin qtr_d = quarter_t'(2); sda_oe_d = 1'b0; end
          default: begin
            state_d = IDLE;
            qtr_d   = '0;
            fin_d   = 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      qtr_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      err_q      <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      busy_q     <= busy_d;
      fin_q      <= fin_d;
      err_q      <= err_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_writer.sv
// Bench for i2c_master_writer: two instances (3 bytes/div 1, 1 byte/div 5) with a pulled-up slave model.
module tb_i2c_master_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st0, st1;
  logic [23:0] dat0;
  logic [7:0]  dat1;
  logic        busy0, fin0, err0, scl0;
  logic        busy1, fin1, err1, scl1;
  wire         sda0, sda1;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fincnt0 = 0;
  int          ntx0 = 0;

  // slave model state, one slot per instance
  logic        sl_drv   [2];
  logic        prev_scl [2];
  logic        prev_sda [2];
  logic [7:0]  sl_shift [2];
  logic [7:0]  ackmask  [2];
  int          bitcnt   [2];
  int          ngot     [2];
  int          starts   [2];
  int          stops    [2];
  int          nrise    [2];
  int          rise_t   [2][2];
  logic [7:0]  got      [2][8];

  pullup (sda0);
  pullup (sda1);
  assign sda0 = sl_drv[0] ? 1'b0 : 1'bz;
  assign sda1 = sl_drv[1] ? 1'b0 : 1'bz;

  i2c_master_writer #(.NBYTES(3), .CLK_DIV(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(st0), .i_dat(dat0),
    .o_busy(busy0), .o_finished(fin0), .o_ack_err(err0), .o_sclk(scl0), .o_sdat(sda0)
  );

  i2c_master_writer #(.NBYTES(1), .CLK_DIV(5)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(st1), .i_dat(dat1),
    .o_busy(busy1), .o_finished(fin1), .o_ack_err(err1), .o_sclk(scl1), .o_sdat(sda1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (fin0) fincnt0++;

  // Whenever the master enables its SDA driver the pad must read low.
  always @(negedge clk) begin
    if (!rst && u0.sda_oe_q) assert (sda0 == 1'b0) else $error("FAIL od_drive0 sda=%b req=0", sda0);
    if (!rst && u1.sda_oe_q) assert (sda1 == 1'b0) else $error("FAIL od_drive1 sda=%b req=0", sda1);
  end

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic slave_step(input int k, input logic scl, input logic sda);
    if (prev_scl[k] && scl && sda != prev_sda[k]) begin
      if (!sda) begin
        starts[k]++;
        bitcnt[k] = 0;
        ngot[k]   = 0;
        nrise[k]  = 0;
      end else begin
        stops[k]++;
      end
    end else if (!prev_scl[k] && scl) begin
      if (nrise[k] < 2) begin
        rise_t[k][nrise[k]] = cyc;
        nrise[k]++;
      end
      if (bitcnt[k] < 8) begin
        sl_shift[k] = {sl_shift[k][6:0], sda};
        bitcnt[k]++;
        if (bitcnt[k] == 8 && ngot[k] < 8) begin
          got[k][ngot[k]] = sl_shift[k];
          ngot[k]++;
        end
      end else if (bitcnt[k] == 8) begin
        bitcnt[k] = 9;
      end
    end else if (prev_scl[k] && !scl) begin
      if (bitcnt[k] == 8 && ngot[k] > 0 && ackmask[k][ngot[k]-1]) sl_drv[k] = 1'b1;
      else if (bitcnt[k] == 9) begin
        sl_drv[k] = 1'b0;
        bitcnt[k] = 0;
      end
    end
    prev_scl[k] = scl;
    prev_sda[k] = sda;
  endtask

  always @(negedge clk) begin
    slave_step(0, scl0, sda0);
    slave_step(1, scl1, sda1);
  end

  function automatic logic busy_of(input int k);
    return (k == 0) ? busy0 : busy1;
  endfunction

  function automatic logic err_of(input int k);
    return (k == 0) ? err0 : err1;
  endfunction

  function automatic logic fin_of(input int k);
    return (k == 0) ? fin0 : fin1;
  endfunction

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (busy_of(k) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("idle_timeout", 1, 0);
  endtask

  // Reference: bytes go out MSB-first until the first NACKed byte (inclusive);
  // every quarter costs CLK_DIV cycles, 2 for START, 36 per byte, 3 for STOP.
  task automatic run_txn(input int k, input logic [23:0] data, input logic [7:0] mask);
    int   n, cd, nsent, exp_lat, acc, to;
    logic exp_err, fin;
    n       = (k == 0) ? 3 : 1;
    cd      = (k == 0) ? 1 : 5;
    nsent   = n;
    exp_err = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (!mask[j]) begin
        nsent   = j + 1;
        exp_err = 1'b1;
        break;
      end
    end
    exp_lat = (2 + 36 * nsent + 3) * cd;
    wait_idle(k);
    ackmask[k] = mask;
    if (k == 0) begin dat0 = data; st0 = 1'b1; ntx0++; end
    else        begin dat1 = data[7:0]; st1 = 1'b1; end
    @(posedge clk); #1;
    acc = cyc;
    st0 = 1'b0;
    st1 = 1'b0;
    check("busy_on", busy_of(k), 1);
    check("err_clear", err_of(k), 0);
    to  = 0;
    fin = 1'b0;
    while (!fin && to < exp_lat + 100) begin
      @(posedge clk); #1;
      to++;
      fin = fin_of(k);
    end
    check("latency", cyc - acc, exp_lat);
    check("ack_err", err_of(k), exp_err);
    check("nbytes", ngot[k], nsent);
    for (int j = 0; j < nsent; j++) check("byte", got[k][j], data[8*(n-1-j) +: 8]);
    @(posedge clk); #1;
    check("busy_off", busy_of(k), 0);
  endtask

  initial begin
    logic [23:0] d;
    logic [7:0]  m;
    int          s0, f0, n;

    for (int k = 0; k < 2; k++) begin
      sl_drv[k] = 1'b0; prev_scl[k] = 1'b1; prev_sda[k] = 1'b1; sl_shift[k] = '0;
      ackmask[k] = '1; bitcnt[k] = 0; ngot[k] = 0; starts[k] = 0; stops[k] = 0;
      nrise[k] = 0; rise_t[k][0] = 0; rise_t[k][1] = 0;
    end
    rst = 1'b1; st0 = 1'b0; st1 = 1'b0; dat0 = '0; dat1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl0", scl0, 1);   check("rst_sda0", sda0, 1);
    check("rst_busy0", busy0, 0); check("rst_fin0", fin0, 0);
    check("rst_err0", err0, 0);   check("rst_scl1", scl1, 1);
    check("rst_busy1", busy1, 0); check("rst_sda1", sda1, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed: all ACK, then NACK on the first byte, then recovery
    run_txn(0, 24'h341E12, 8'h07);
    run_txn(0, 24'h341E12, 8'h06);
    run_txn(0, 24'hC3_5A_81, 8'h07);

    for (int i = 0; i < 6; i++) begin
      d = 24'($urandom);
      m = 8'h00;
      for (int j = 0; j < 3; j++) m[j] = ($urandom_range(0, 3) != 0);
      run_txn(0, d, m);
    end

    // slow instance: SCL period and latency
    run_txn(1, 24'h0000A5, 8'h01);
    check("scl_period", rise_t[1][1] - rise_t[1][0], 20);
    for (int i = 0; i < 3; i++) run_txn(1, 24'($urandom), {7'd0, 1'($urandom_range(0, 1))});

    // start pulses during a transfer are ignored
    s0 = starts[0];
    f0 = fincnt0;
    d  = 24'($urandom);
    ackmask[0] = 8'h07;
    dat0 = d;
    st0  = 1'b1;
    ntx0++;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      st0 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    st0 = 1'b0;
    wait_idle(0);
    repeat (3) @(posedge clk);
    #1;
    check("one_start", starts[0] - s0, 1);
    check("one_finish", fincnt0 - f0, 1);
    check("pulse_nbytes", ngot[0], 3);
    check("pulse_byte0", got[0][0], d[23:16]);

    // start held high: next START appears the cycle after o_finished
    s0 = starts[0];
    dat0 = d;
    st0  = 1'b1;
    ntx0 += 2;
    @(posedge clk); #1;
    n = 0;
    while (!fin0 && n < 300) begin @(posedge clk); #1; n++; end
    check("held_fin_seen", fin0, 1);
    check("held_fin_sda", sda0, 1);
    check("held_fin_busy", busy0, 1);
    @(posedge clk); #1;
    st0 = 1'b0;
    check("b2b_busy", busy0, 1);
    check("b2b_scl", scl0, 1);
    check("b2b_sda", sda0, 0);
    wait_idle(0);
    check("b2b_starts", starts[0] - s0, 2);
    check("b2b_byte2", got[0][2], d[7:0]);
    check("starts_total", starts[0], ntx0);
    check("stops_total", stops[0], ntx0);

    // reset mid-byte aborts with no STOP and no o_finished
    ackmask[0] = 8'h07;
    dat0 = 24'($urandom);
    st0  = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_busy", busy0, 1);
    f0  = fincnt0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_scl", scl0, 1);
    check("abort_sda", sda0, 1);
    check("abort_busy", busy0, 0);
    check("abort_fin", fin0, 0);
    repeat (150) @(posedge clk);
    #1;
    check("abort_no_fin", fincnt0 - f0, 0);
    check("abort_idle_scl", scl0, 1);

    // recovers normally after the abort
    run_txn(0, 24'h341E12, 8'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
